// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts
// one command byte (LSB first, odd parity, stop) on device clock edges and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int FRAME_TIMEOUT  = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_W = 21;
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_DEV, S_SHIFT, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [2:0]       clk_s_q;
    logic [1:0]       dat_s_q;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_sync, dat_sync, fe, frame_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser stages; bit 2 of clk_s_q is the edge-detect history.
    assign clk_sync = clk_s_q[1];
    assign dat_sync = dat_s_q[1];
    assign fe       = clk_s_q[2] & ~clk_s_q[1];
    assign frame_to = (fcnt_q >= FRAME_LAST);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        fcnt_d    = fcnt_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                fcnt_d = '0;
                if (tx_valid) begin
                    shreg_d  = tx_data;
                    par_d    = ~^tx_data;
                    bitcnt_d = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = sat_inc(cnt_q);
                if (cnt_q >= INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // The start timeout is measured from the request cycle.
                cnt_d     = sat_inc(cnt_q);
                data_oe_d = 1'b1;
                state_d   = S_WAIT_DEV;
            end
            S_WAIT_DEV: begin
                cnt_d     = sat_inc(cnt_q);
                data_oe_d = 1'b1;
                if (fe) begin
                    data_oe_d = ~shreg_q[0];
                    bitcnt_d  = 4'd1;
                    fcnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d   = S_SHIFT;
                end else if (cnt_q >= START_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_SHIFT: begin
                fcnt_d = sat_inc(fcnt_q);
                if (frame_to) begin
                    state_d = S_ERR;
                end else if (fe) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q <= 4'd7) begin
                        data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else if (bitcnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        state_d = dat_sync ? S_ERR : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                fcnt_d = sat_inc(fcnt_q);
                if (frame_to) begin
                    state_d = S_ERR;
                end else if (clk_sync && dat_sync) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pin drives are registered from the next state so they never glitch.
        if (state_d inside {S_IDLE, S_INHIBIT, S_WAIT_IDLE, S_DONE, S_ERR}) begin
            data_oe_d = 1'b0;
        end
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            clk_s_q   <= 3'b111;
            dat_s_q   <= 2'b11;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
            clk_s_q   <= {clk_s_q[1:0], ps2_clk_in};
            dat_s_q   <= {dat_s_q[0], ps2_data_in};
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
